// File: rtl/rx_frame_sequencer.sv
// Serial receive sequencer: start validation, mid-bit sampling, stop check, valid/ready delivery.
// Optional even-parity bit between data and stop when RX_PARITY_EN is defined.
module rx_frame_sequencer #(
    parameter int CLKS_PER_BIT = 5,
    parameter int DATA_BITS    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_en,
    input  logic                 data_in,
    input  logic                 rx_ready,
    input  logic                 overrun_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP,
        RECOVER
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS:0]   shift_in;
    logic                 par_err;
    logic                 tick;
    logic                 cnt_clr;
    logic                 shift_en;
    logic                 par_en;
    logic                 deliver;
    logic                 ferr;
    logic                 perr;

    assign tick     = (clk_cnt == LAST);
    assign shift_in = {data_in, shift};

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        deliver  = 1'b0;
        ferr     = 1'b0;
        perr     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_en && !data_in) state_n = START;
            end
            START: begin
                if (clk_cnt == HALF) begin
                    cnt_clr = 1'b1;
                    state_n = data_in ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == BLAST) begin
`ifdef RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    cnt_clr = 1'b1;
                    par_en  = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    cnt_clr = 1'b1;
                    if (!data_in) begin
                        ferr    = 1'b1;
                        state_n = RECOVER;
                    end else if (par_err) begin
                        perr    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            RECOVER: begin
                if (data_in) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_err <= 1'b0;
        end else begin
            if (state == IDLE || state == RECOVER || cnt_clr)
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + 1'b1;
            if (state == IDLE)  bit_cnt <= '0;
            else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shift <= shift_in[DATA_BITS:1];
            // Odd population over data plus parity bit means even parity failed
            if (state == IDLE) par_err <= 1'b0;
            else if (par_en)   par_err <= ^shift_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_error  <= ferr;
            parity_error <= perr;
            busy         <= (state_n != IDLE);
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (overrun_clr) overrun <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/rx_frame_sequencer.md
# rx_frame_sequencer

Self-contained sequencer for the serial receive path. It detects a start bit on the idle-high line and validates it at mid-bit. It then times mid-bit sampling of each data bit with an internal clock counter, a bit counter and a shift register, and checks the stop bit. Completed words go downstream over a valid/ready handshake, with frame-error, parity-error and overrun reporting; it sits between the line input and the consumer of received words.

## Interface
- CLKS_PER_BIT, 5, clock cycles per serial bit; legal range ≥ 3
- DATA_BITS, 4, data bits per frame, LSB first; legal range 1–16
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- rx_en  input  1  permits IDLE→START; does not abort a frame in progress
- data_in  input  1  serial line, idle high
- rx_ready  input  1  downstream accepts word when rx_valid && rx_ready
- overrun_clr  input  1  synchronous clear of overrun
- rx_data  output  DATA_BITS  received word, stable while rx_valid=1
- rx_valid  output  1  word available
- frame_error  output  1  one-cycle pulse: stop bit sampled 0
- parity_error  output  1  one-cycle pulse: parity mismatch (tied 0 without parity)
- overrun  output  1  sticky: a good word was dropped because rx_valid was still pending
- busy  output  1  state ≠ IDLE

## Operation
- States: IDLE, START, DATA, PARITY (parity builds only), STOP, RECOVER.
- Width and arithmetic:
  - HALF = CLKS_PER_BIT/2, floor (2 for 5).
  - clk_cnt width = $clog2(CLKS_PER_BIT).
  - bit_cnt width = $clog2(DATA_BITS+1).
- IDLE: clk_cnt=0, bit_cnt=0. rx_en=1 && data_in=0 → START.
- START: clk_cnt increments.
  - At clk_cnt==HALF with data_in=0 → DATA, clk_cnt=0.
  - At clk_cnt==HALF with data_in=1 → IDLE (glitch); no flags.
- DATA: clk_cnt increments; at clk_cnt==CLKS_PER_BIT-1:
  - Sample data_in into the shift register MSB, shifting right, so the first bit lands in rx_data[0].
  - Increment bit_cnt; clear clk_cnt.
  - After the DATA_BITS-th sample → PARITY (if built), else STOP.
- PARITY: sample after CLKS_PER_BIT cycles. Even parity over data+parity bit; record mismatch → STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - data_in=0: frame_error pulse, word discarded → RECOVER.
  - data_in=1 with parity mismatch: parity_error pulse, word discarded → IDLE.
  - data_in=1 otherwise: deliver the word (see Handshake) → IDLE.
- RECOVER: wait for data_in=1 → IDLE. Prevents a held-low line (break) from retriggering.
- Handshake:
  - Delivery with rx_valid=0, or with rx_valid && rx_ready in the same cycle: load rx_data, rx_valid=1.
  - Delivery with rx_valid=1 && rx_ready=0: new word dropped, overrun←1, rx_data unchanged.
  - rx_valid falls the cycle after acceptance unless a new word loads in that same cycle.
- overrun: cleared by overrun_clr. Set has priority over a clear in the same cycle.
- rx_en=0 mid-frame: frame completes normally.
- reset_n low at any time: immediately IDLE, all outputs 0, counters and shift register 0.

## Timing
- Notation: E0 = edge at which IDLE samples data_in=0; C = CLKS_PER_BIT; P = 1 if parity built, else 0.
- Start check at E0+HALF+1.
- Data bit k (0-based) sampled at E0+HALF+1+(k+1)·C.
- Stop sampled at E0+HALF+1+(DATA_BITS+P+1)·C.
- rx_valid, frame_error and parity_error assert at the stop-sample edge (registered outputs, visible the following cycle).
- Defaults, no parity: stop at E0+28.
- Earliest new start after a good frame: the edge after stop sample.
- All outputs registered; no combinational input→output paths.

## Configuration
- RX_PARITY_EN defined:
  - One even-parity bit between data and stop; PARITY state present.
  - Mismatch → parity_error pulse and word discarded.
- RX_PARITY_EN undefined:
  - No parity bit; PARITY state omitted.
  - parity_error tied 0; stop follows the last data bit.

## Test plan
- Defaults, no parity, rx_ready=1. Frame 0,[0,1,0,1],1 at 5 cycles/bit → rx_valid asserts at E0+28, rx_data=4'b1010, no flags.
- 2-cycle low glitch on idle line → START returns to IDLE at E0+3; busy low thereafter; no rx_valid.
- Stop bit driven 0, line held low 20 more cycles → frame_error single pulse; busy stays 1 until line high, then IDLE.
- rx_ready=0, two good frames 4'h3 then 4'hC → rx_data stays 4'h3, overrun=1. overrun_clr pulse → overrun=0.
- With RX_PARITY_EN, data 4'b0111 with parity bit 1 → rx_data=4'b0111. Same frame with parity bit 0 → parity_error pulse, no rx_valid.
- reset_n pulsed low mid-DATA → all outputs 0 immediately. Next full frame received correctly.
